// File: rtl/fir2d_pkg.sv
// Shared constants for the 5x5 2D FIR frame controller: FSM encoding, tap/pixel widths,
// identity coefficient bank and the packed line-buffer column word.
package fir2d_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam int NUM_TAPS  = 25;
  localparam int TAP_W     = 16;
  localparam int PIX_W     = 8;
  localparam int IDENT_TAP = 12;

  localparam logic [NUM_TAPS*TAP_W-1:0] COEFF_IDENTITY =
    {{((NUM_TAPS-IDENT_TAP-1)*TAP_W){1'b0}}, 16'h0100, {(IDENT_TAP*TAP_W){1'b0}}};

  typedef logic [PIX_W-1:0] pix_t;

  // One column of the four stored rows; r0 is the oldest row.
  typedef struct packed {
    pix_t r3;
    pix_t r2;
    pix_t r1;
    pix_t r0;
  } lb_word_t;

  function automatic lb_word_t lb_shift(input lb_word_t w, input pix_t p);
    lb_word_t n;
    n.r0 = w.r1;
    n.r1 = w.r2;
    n.r2 = w.r3;
    n.r3 = p;
    return n;
  endfunction

endpackage

// File: rtl/fir2d_line_buffer.sv
// Four-row shift memory indexed by column: combinational read, write shifts the column up.
// Reads see the pre-write word at the same address; no backpressure, the writer decides.
module fir2d_line_buffer
  import fir2d_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  pix_t              wr_pix,
  output lb_word_t          rd_word
);

  lb_word_t mem [DEPTH];

  assign rd_word = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= lb_shift(rd_word, wr_pix);
    end
  end

endmodule

// File: rtl/fir2d_frame_ctrl.sv
// Frame sequencer for the 5x5 FIR cascade: line buffers, coefficient banks, completion count.
// Window appears 1 cycle after each accept; s_ready only in FILL/RUN, cascade never stalls.
module fir2d_frame_ctrl
  import fir2d_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [7:0]                s_pixel,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic                      coeff_we,
  input  logic [4:0]                coeff_addr,
  input  logic [15:0]               coeff_wdata,
  output logic [NUM_TAPS*TAP_W-1:0] coeff_flat,
  output logic [7:0]                pixel0,
  output logic [7:0]                pixel1,
  output logic [7:0]                pixel2,
  output logic [7:0]                pixel3,
  output logic [7:0]                pixel4,
  output logic                      fir_in_valid,
  output logic                      fir_rst,
  input  logic                      fir_out_valid,
  output logic                      busy,
  output logic                      frame_done
);

  localparam int PIX_TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W     = $clog2(PIX_TOTAL + 1);
  localparam logic [CNT_W-1:0] DONE_CNT = CNT_W'((IMG_HEIGHT - 4) * IMG_WIDTH);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] FILL_ROW = ROW_W'(3);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  logic [1:0]                  state;
  logic [COL_W-1:0]            col;
  logic [ROW_W-1:0]            row;
  logic [CNT_W-1:0]            out_cnt;
  logic [CNT_W-1:0]            cnt_next;
  logic                        fir_rst_q;
  logic [NUM_TAPS*TAP_W-1:0]   coeff_shadow;
  logic [NUM_TAPS*TAP_W-1:0]   coeff_active;
  logic                        accept;
  logic                        last_col;
  logic                        active_frame;
  lb_word_t                    lb_rd;

  assign s_ready      = (state == ST_FILL) || (state == ST_RUN);
  assign accept       = s_valid && s_ready;
  assign last_col     = (col == LAST_COL);
  assign active_frame = (state != ST_IDLE);
  assign busy         = active_frame;
  assign fir_rst      = rst | fir_rst_q;
  assign coeff_flat   = coeff_active;
  assign cnt_next     = out_cnt + {{(CNT_W-1){1'b0}}, fir_out_valid};

  fir2d_line_buffer #(
    .DEPTH  (IMG_WIDTH),
    .ADDR_W (COL_W)
  ) u_lb (
    .clk     (clk),
    .wr_en   (accept),
    .addr    (col),
    .wr_pix  (s_pixel),
    .rd_word (lb_rd)
  );

  // Coefficient banks: shadow takes writes at any time, active only moves on an accepted start.
  // Non-blocking copy means a write coinciding with start lands after the commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      coeff_shadow <= COEFF_IDENTITY;
      coeff_active <= COEFF_IDENTITY;
    end else begin
      if (state == ST_IDLE && start) begin
        coeff_active <= coeff_shadow;
      end
      if (coeff_we && (coeff_addr < 5'(NUM_TAPS))) begin
        coeff_shadow[{coeff_addr, 4'b0000} +: TAP_W] <= coeff_wdata;
      end
    end
  end

  // Window registers and raster position.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel0 <= '0;
      pixel1 <= '0;
      pixel2 <= '0;
      pixel3 <= '0;
      pixel4 <= '0;
      col    <= '0;
      row    <= '0;
    end else if (state == ST_IDLE) begin
      if (start) begin
        col <= '0;
        row <= '0;
      end
    end else if (accept) begin
      pixel0 <= lb_rd.r0;
      pixel1 <= lb_rd.r1;
      pixel2 <= lb_rd.r2;
      pixel3 <= lb_rd.r3;
      pixel4 <= s_pixel;
      if (last_col) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Frame FSM, completion counting and cascade control strobes; abort overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      out_cnt      <= '0;
      fir_in_valid <= 1'b0;
      frame_done   <= 1'b0;
      fir_rst_q    <= 1'b0;
    end else begin
      frame_done   <= 1'b0;
      fir_rst_q    <= 1'b0;
      fir_in_valid <= accept && (state == ST_RUN) && !abort;

      if (active_frame && fir_out_valid) begin
        out_cnt <= cnt_next;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FILL;
            out_cnt   <= '0;
            fir_rst_q <= 1'b1;
          end
        end
        ST_FILL: begin
          if (accept && last_col && (row == FILL_ROW)) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (accept && last_col && (row == LAST_ROW)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cnt_next >= DONE_CNT) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (abort && active_frame) begin
        state      <= ST_IDLE;
        frame_done <= 1'b0;
        fir_rst_q  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/fir2d_frame_ctrl.md
Name: fir2d_frame_ctrl

Overview:
- Frame-level controller that sequences the 5x5 systolic 2D FIR cascade.
- Accepts a raster pixel stream through a valid/ready handshake and stores the 4 previous image rows in line buffers.
- Presents 5 vertically aligned pixels per column (pixel0..pixel4) plus in_valid to the cascade.
- Owns the double-buffered 25-tap coefficient bank and detects frame completion by counting cascade out_valid pulses.

Parameters:
- IMG_WIDTH, 640, pixels per row (>=5)
- IMG_HEIGHT, 480, rows per frame (>=5)
- COL_W, 10, column counter width, >= clog2(IMG_WIDTH)
- ROW_W, 9, row counter width, >= clog2(IMG_HEIGHT)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins a frame when IDLE
- abort  in  1  pulse; abandons the current frame
- s_pixel  in  8  raster input pixel
- s_valid  in  1  input pixel valid
- s_ready  out  1  controller accepts a pixel this cycle
- coeff_we  in  1  shadow coefficient write strobe
- coeff_addr  in  5  tap index 0..24, row-major (index = 5*row + col)
- coeff_wdata  in  16  signed tap value
- coeff_flat  out  400  active taps; tap k occupies bits [16k+15:16k]
- pixel0..pixel4  out  8 each  column window; pixel0 = oldest row (r-4), pixel4 = current row r
- fir_in_valid  out  1  window valid to cascade
- fir_rst  out  1  reset to cascade
- fir_out_valid  in  1  cascade out_valid
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE. s_ready, fir_in_valid, busy and frame_done = 0. pixel0..4 = 0. fir_rst = 1 during rst.
- Coefficient reset: shadow and active banks both hold identity (tap 12 = 16'h0100, all others 0). Line buffer contents are don't-care.
- Coefficient writes: coeff_we writes shadow[coeff_addr] in any state. Addresses 25..31 are ignored. The active bank (coeff_flat) only changes on an accepted start.
  - If coeff_we and start coincide, the commit copies the pre-write shadow. The write lands in shadow and takes effect at the next frame.
- States: IDLE, FILL, RUN, DRAIN.
  - IDLE --start--> FILL. On entry: active <= shadow, col = row = 0, out_cnt = 0, fir_rst pulses 1 for one cycle.
  - start is ignored outside IDLE.
- Accept rule: s_ready = 1 in FILL and RUN only. A pixel is accepted when s_valid && s_ready.
- On each accept at column c:
  - Outputs: pixel0 <= lb0[c], pixel1 <= lb1[c], pixel2 <= lb2[c], pixel3 <= lb3[c], pixel4 <= s_pixel.
  - Line buffers: lb0[c] <= lb1[c], lb1[c] <= lb2[c], lb2[c] <= lb3[c], lb3[c] <= s_pixel.
  - Read-before-write at the same address.
  - col increments and wraps at IMG_WIDTH-1 with row++.
- fir_in_valid is registered: 1 in the cycle after an accept made in RUN, 0 otherwise. The latency from accept to window is 1 cycle.
- pixel0..4 hold their value when no accept occurs. The cascade has no stall, so gaps in s_valid simply produce gaps in fir_in_valid.
- FILL -> RUN after the last pixel of row 3 is accepted (row 3, col IMG_WIDTH-1).
- RUN -> DRAIN after the last pixel of row IMG_HEIGHT-1 is accepted.
- out_cnt increments on fir_out_valid in FILL, RUN and DRAIN. fir_out_valid is ignored in IDLE.
- Completion: when out_cnt reaches (IMG_HEIGHT-4)*IMG_WIDTH in DRAIN, frame_done = 1 for one cycle and the state returns to IDLE.
- busy = 1 whenever state != IDLE.
- abort in any non-IDLE state:
  - Next state is IDLE, s_ready drops the next cycle, fir_in_valid is forced to 0.
  - fir_rst pulses for one cycle; no frame_done is issued.
  - Active coefficients are kept.
- Reset mid-frame behaves like abort, and in addition restores the identity coefficients.
- Width rules: out_cnt is wide enough for IMG_HEIGHT*IMG_WIDTH. coeff_wdata is stored unmodified.
- Horizontal borders are not padded. The first 4 windows of each row mix columns from the previous row; this is documented and accepted.

Decomposition:
- Shared package fir2d_pkg holds:
  - state encoding (IDLE = 0, FILL = 1, RUN = 2, DRAIN = 3)
  - NUM_TAPS = 25, TAP_W = 16, PIX_W = 8
  - identity coefficient constant (tap 12 = 16'h0100)
- One sub-module: fir2d_line_buffer, a 4-row read-before-write shift memory indexed by column (depth IMG_WIDTH, width 32).

Test Plan (IMG_WIDTH = 8, IMG_HEIGHT = 6):
- Identity streaming: reset, start, stream pixel = 8*row + col with s_valid always 1.
  - Accepts 48 pixels; fir_in_valid is high for exactly 16 cycles.
  - First window (row 4, col 0): pixel0..4 = 0, 8, 16, 24, 32.
- Completion: drive 16 fir_out_valid pulses.
  - frame_done pulses exactly once, on the 16th; busy falls the same cycle; s_ready = 0 afterwards.
- Backpressure gaps: s_valid toggled 1/0 during RUN.
  - fir_in_valid appears only the cycle after each accept; window contents are identical to the gap-free run.
- Coefficient commit: write addr 0 = 16'h0040 while IDLE, then start.
  - coeff_flat[15:0] = 16'h0040 from the start cycle onward.
  - A write of addr 0 = 16'h0080 mid-frame leaves coeff_flat unchanged until the next start.
- Simultaneous coeff_we and start: write addr 12 = 16'h0200 on the start cycle.
  - The active tap 12 equals the prior shadow value; shadow holds 16'h0200.
- Abort mid-RUN, then rst mid-FILL: abort gives IDLE, a one-cycle fir_rst, no frame_done.
  - The next start runs a full clean frame.
  - rst returns coeff_flat to identity, outputs to 0 and s_ready to 0.
